// File: rtl/instr_fetch.sv
// Instruction fetch: PC, combinational memory port, small {instr, pc} buffer
// and valid/ready hand-off to decode, with redirect and end-of-memory stop.
module instr_fetch #(
   parameter logic [15:0] RESET_PC   = 16'h0000,
   parameter int          MEM_WORDS  = 32,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   output logic        mem_enable_o,
   output logic [15:0] mem_addr_o,
   input  logic [31:0] mem_instr_i,
   output logic        instr_valid_o,
   input  logic        instr_ready_i,
   output logic [31:0] instr_o,
   output logic [15:0] instr_pc_o,
   input  logic        redirect_i,
   input  logic [15:0] redirect_pc_i,
   output logic        done_o
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   typedef enum logic [1:0] {FETCH, DRAIN, DONE} state_t;

   state_t          state_reg, state_next;
   logic [15:0]     pc_reg, pc_next;
   logic [PW-1:0]   rd_ptr_reg, wr_ptr_reg;
   logic [CW-1:0]   count_reg, count_next;
   logic [31:0]     fifo_instr [FIFO_DEPTH];
   logic [15:0]     fifo_pc    [FIFO_DEPTH];
   logic            fetch, pop, in_range, last_word, not_empty;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign not_empty     = (count_reg != '0);
   assign instr_valid_o = not_empty & ~redirect_i;
   assign pop           = instr_valid_o & instr_ready_i;
   assign in_range      = ({2'b00, pc_reg[15:2]} < 16'(MEM_WORDS));
   assign last_word     = ({2'b00, pc_reg[15:2]} == 16'(MEM_WORDS - 1));

   // rst_ni gating keeps the memory port quiet while reset is held.
   assign fetch = rst_ni & (state_reg == FETCH) & ~redirect_i & in_range &
                  ((count_reg < CW'(FIFO_DEPTH)) | pop);

   assign mem_enable_o = fetch;
   assign mem_addr_o   = pc_reg;
   assign done_o       = (state_reg == DONE);
   assign instr_o      = not_empty ? fifo_instr[rd_ptr_reg] : 32'h0;
   assign instr_pc_o   = not_empty ? fifo_pc[rd_ptr_reg]    : 16'h0;

   always_comb begin
      count_next = count_reg;
      pc_next    = pc_reg;
      state_next = state_reg;
      if (redirect_i) begin
         count_next = '0;
         pc_next    = {redirect_pc_i[15:2], 2'b00};
      end else begin
         if (fetch && !pop)
            count_next = count_reg + 1'b1;
         else if (!fetch && pop)
            count_next = count_reg - 1'b1;
         if (fetch)
            pc_next = pc_reg + 16'd4;
      end

      case (state_reg)
         FETCH: begin
            // Out-of-range PC: skip straight to DONE when nothing is left to drain.
            if (!in_range)
               state_next = (count_next == '0) ? DONE : DRAIN;
            else if (fetch && last_word)
               state_next = DRAIN;
         end
         DRAIN:   if (count_next == '0) state_next = DONE;
         DONE:    state_next = DONE;
         default: state_next = FETCH;
      endcase
      if (redirect_i)
         state_next = FETCH;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_reg  <= FETCH;
         pc_reg     <= RESET_PC & 16'hFFFC;
         count_reg  <= '0;
         rd_ptr_reg <= '0;
         wr_ptr_reg <= '0;
      end else begin
         state_reg <= state_next;
         pc_reg    <= pc_next;
         count_reg <= count_next;
         if (redirect_i) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
         end else begin
            if (fetch) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            if (pop)   rd_ptr_reg <= ptr_inc(rd_ptr_reg);
         end
      end
   end

   // Buffer storage needs no reset; the count qualifies every read.
   always_ff @(posedge clk_i) begin
      if (fetch) begin
         fifo_instr[wr_ptr_reg] <= mem_instr_i;
         fifo_pc[wr_ptr_reg]    <= pc_reg;
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: vector table, hand sequences for redirect/reset/end
// of memory, and random traffic checked against a queue-based model.
module tb_instr_fetch;

   localparam int          MW  = 32;
   localparam int          D   = 2;
   localparam logic [15:0] RPC = 16'h0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        mem_enable;
   logic [15:0] mem_addr;
   logic [31:0] mem_instr;
   logic        instr_valid;
   logic        instr_ready = 1'b0;
   logic [31:0] instr;
   logic [15:0] instr_pc;
   logic        redirect = 1'b0;
   logic [15:0] redirect_pc = 16'h0;
   logic        done;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   instr_fetch #(.RESET_PC(RPC), .MEM_WORDS(MW), .FIFO_DEPTH(D)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .mem_enable_o(mem_enable), .mem_addr_o(mem_addr), .mem_instr_i(mem_instr),
      .instr_valid_o(instr_valid), .instr_ready_i(instr_ready),
      .instr_o(instr), .instr_pc_o(instr_pc),
      .redirect_i(redirect), .redirect_pc_i(redirect_pc), .done_o(done)
   );

   logic [31:0] mem [MW];

   always_comb begin
      int w;
      w = int'(mem_addr[15:2]);
      if (w < MW) mem_instr = mem[w];
      else        mem_instr = 32'hDEADBEEF;
   end

   // Reference model: queue of fetched words, fetch address, end flags.
   typedef struct { logic [31:0] instr; logic [15:0] pc; } ent_t;
   ent_t        q[$];
   logic [15:0] m_pc;
   bit          m_ended, m_done;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_pc    = RPC & 16'hFFFC;
      m_ended = 1'b0;
      m_done  = 1'b0;
   endtask

   task automatic drive(input bit rdy, input bit redir, input logic [15:0] rpc);
      instr_ready = rdy;
      redirect    = redir;
      redirect_pc = rpc;
      #1;
   endtask

   // Compare this cycle against the model, advance the model, move to next negedge.
   task automatic step();
      bit exp_valid, exp_pop, exp_en;
      int word;
      word      = int'(m_pc >> 2);
      exp_valid = (q.size() != 0) && !redirect;
      exp_pop   = exp_valid && instr_ready;
      exp_en    = !m_ended && !redirect && (word < MW) && ((q.size() < D) || exp_pop);
      chk("valid",  32'(instr_valid), 32'(exp_valid));
      chk("enable", 32'(mem_enable),  32'(exp_en));
      chk("addr",   32'(mem_addr),    32'(m_pc));
      chk("done",   32'(done),        32'(m_done));
      chk("instr",    instr,            (q.size() != 0) ? q[0].instr : 32'h0);
      chk("instr_pc", 32'(instr_pc),    (q.size() != 0) ? 32'(q[0].pc) : 32'h0);
      if (redirect) begin
         q.delete();
         m_pc    = redirect_pc & 16'hFFFC;
         m_ended = 1'b0;
         m_done  = 1'b0;
      end else begin
         if (exp_pop) void'(q.pop_front());
         if (exp_en) begin
            q.push_back('{mem[word], m_pc});
            if (word == MW - 1) m_ended = 1'b1;
            m_pc = m_pc + 16'd4;
         end else if (!m_ended && word >= MW) begin
            m_ended = 1'b1;
         end
         if (m_ended && q.size() == 0) m_done = 1'b1;
      end
      @(negedge clk);
   endtask

   typedef struct {
      bit          rdy;
      bit          exp_valid;
      logic [15:0] exp_pc;
      logic [31:0] exp_instr;
      bit          exp_en;
   } vec_t;
   vec_t tbl[9];

   initial begin
      for (int k = 0; k < MW; k++) mem[k] = 32'h1000 + 32'(k);
      mem[3] = 32'h0;

      tbl[0] = '{0, 0, 16'd0,  32'h0,    1};
      tbl[1] = '{0, 1, 16'd0,  32'h1000, 1};
      tbl[2] = '{0, 1, 16'd0,  32'h1000, 0};
      tbl[3] = '{0, 1, 16'd0,  32'h1000, 0};
      tbl[4] = '{0, 1, 16'd0,  32'h1000, 0};
      tbl[5] = '{1, 1, 16'd0,  32'h1000, 1};
      tbl[6] = '{1, 1, 16'd4,  32'h1001, 1};
      tbl[7] = '{1, 1, 16'd8,  32'h1002, 1};
      tbl[8] = '{1, 1, 16'd12, 32'h0,    1};

      // Outputs while reset is held.
      repeat (2) @(negedge clk);
      #1;
      chk("rst_valid",  32'(instr_valid), 32'h0);
      chk("rst_enable", 32'(mem_enable),  32'h0);
      chk("rst_done",   32'(done),        32'h0);
      chk("rst_instr",  instr,            32'h0);
      chk("rst_ipc",    32'(instr_pc),    32'h0);
      chk("rst_addr",   32'(mem_addr),    32'(RPC));

      // Release, then stall decode for 5 cycles and resume.
      rst_n = 1'b1;
      model_reset();
      for (int i = 0; i < 9; i++) begin
         drive(tbl[i].rdy, 0, 16'h0);
         chk("tbl_valid",  32'(instr_valid), 32'(tbl[i].exp_valid));
         chk("tbl_pc",     32'(instr_pc),    32'(tbl[i].exp_pc));
         chk("tbl_instr",  instr,            tbl[i].exp_instr);
         chk("tbl_enable", 32'(mem_enable),  32'(tbl[i].exp_en));
         step();
      end

      // Stream to the end of memory with ready held high.
      for (int i = 0; i < 40; i++) begin
         drive(1, 0, 16'h0);
         step();
      end
      #1;
      chk("end_done", 32'(done), 32'h1);

      // Redirect to 0, fill the FIFO, then redirect to 0x42.
      drive(1, 1, 16'h0000);
      chk("done_hold_in_redirect", 32'(done), 32'h1);
      step();
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 16'h0);
         step();
      end
      drive(1, 1, 16'h0042);
      chk("redir_valid_gated", 32'(instr_valid), 32'h0);
      chk("redir_no_fetch",    32'(mem_enable),  32'h0);
      step();
      drive(1, 0, 16'h0);
      chk("redir_addr",   32'(mem_addr),    32'h0040);
      chk("redir_fetch",  32'(mem_enable),  32'h1);
      chk("redir_bubble", 32'(instr_valid), 32'h0);
      step();
      drive(1, 0, 16'h0);
      chk("redir_first_pc", 32'(instr_pc), 32'd64);
      step();

      // Redirect beyond the end of memory.
      drive(1, 1, 16'h0100);
      step();
      drive(1, 0, 16'h0);
      chk("oob_no_fetch1", 32'(mem_enable), 32'h0);
      step();
      drive(1, 0, 16'h0);
      chk("oob_no_fetch2", 32'(mem_enable), 32'h0);
      chk("oob_done",      32'(done),       32'h1);
      step();
      drive(1, 1, 16'h0000);
      step();
      drive(1, 0, 16'h0);
      chk("oob_done_clear", 32'(done),       32'h0);
      chk("oob_resume",     32'(mem_enable), 32'h1);
      chk("oob_resume_pc",  32'(mem_addr),   32'h0);
      step();
      for (int i = 0; i < 4; i++) begin
         drive(1, 0, 16'h0);
         step();
      end

      // Asynchronous reset between clock edges.
      drive(1, 0, 16'h0);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_valid",  32'(instr_valid), 32'h0);
      chk("arst_enable", 32'(mem_enable),  32'h0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      drive(1, 0, 16'h0);
      step();
      drive(1, 0, 16'h0);
      chk("arst_first_valid", 32'(instr_valid), 32'h1);
      chk("arst_first_pc",    32'(instr_pc),    32'(RPC));
      step();

      // Random traffic against the model.
      for (int i = 0; i < 800; i++) begin
         drive($urandom_range(0, 9) < 7, $urandom_range(0, 99) < 4,
               16'($urandom_range(0, 16'h00A0)));
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
